// File: rtl/superos_irq_ctrl.sv
// Interrupt aggregator: up to 16 edge/level lines, masked into one registered CPU irq,
// with a lowest-index dispatch vector behind a 16-bit Avalon-MM register window.
module superos_irq_ctrl #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [15:0] MODE_RESET = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  localparam logic [16:0] LINE_LIMIT = 17'd1 << NUM_IRQ;
  localparam logic [15:0] IMPL       = 16'(LINE_LIMIT - 17'd1);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_SWSET   = 3'd5;

  logic [15:0] irq_in_ext;
  logic [15:0] irq_q, irq_d;
  logic [15:0] irq_prev_q, irq_prev_d;
  logic [15:0] pending_q, pending_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] mode_q, mode_d;
  logic [15:0] readdata_q, readdata_d;
  logic        irq_out_q, irq_out_d;
  logic        post_rst_q;

  logic        wr_en;
  logic [15:0] mode_chg;
  logic [15:0] w1c;
  logic [15:0] swset;
  logic [15:0] rise;
  logic [15:0] edge_next;
  logic [15:0] active;
  logic [3:0]  vec_idx;
  logic        vec_valid;

  assign irq_in_ext = 16'(irq_in);

  always_comb begin
    wr_en    = chipselect && !write_n;
    irq_d    = irq_in_ext;
    // First cycle after reset: seed the history with the live input so a line
    // held high through reset is not mistaken for a fresh rising edge.
    irq_prev_d = post_rst_q ? irq_in_ext : irq_q;

    mask_d   = (wr_en && address == ADDR_MASK) ? (writedata & IMPL) : mask_q;
    mode_d   = (wr_en && address == ADDR_MODE) ? (writedata & IMPL) : mode_q;
    mode_chg = mode_q ^ mode_d;
    w1c      = (wr_en && address == ADDR_PENDING) ? writedata : 16'h0000;
    swset    = (wr_en && address == ADDR_SWSET) ? writedata : 16'h0000;

    rise      = irq_q & ~irq_prev_q;
    edge_next = (pending_q & ~w1c) | rise | swset;
    pending_d = ((mode_q & edge_next) | (~mode_q & irq_q)) & ~mode_chg & IMPL;

    active    = pending_q & mask_q;
    irq_out_d = |active;

    vec_idx   = 4'd0;
    vec_valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (active[i]) begin
        vec_idx   = 4'(i);
        vec_valid = 1'b1;
      end
    end

    case (address)
      ADDR_PENDING: readdata_d = pending_q;
      ADDR_MASK:    readdata_d = mask_q;
      ADDR_MODE:    readdata_d = mode_q;
      ADDR_ACTIVE:  readdata_d = active;
      ADDR_VECTOR:  readdata_d = {vec_valid, 11'b0, vec_idx};
      default:      readdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_q      <= 16'h0000;
      irq_prev_q <= 16'h0000;
      pending_q  <= 16'h0000;
      mask_q     <= 16'h0000;
      mode_q     <= MODE_RESET & IMPL;
      readdata_q <= 16'h0000;
      irq_out_q  <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      irq_q      <= irq_d;
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      readdata_q <= readdata_d;
      irq_out_q  <= irq_out_d;
      post_rst_q <= 1'b0;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_out_q;

endmodule

// File: doc/superos_irq_ctrl.md
# superos_irq_ctrl

Interrupt aggregator downstream of the system interval timer and other Avalon-MM peripherals. Collects up to 16 peripheral `irq` lines, latches or tracks them per line (edge or level mode), masks them, and drives a single registered `irq_out` to the CPU. A lowest-index priority vector is provided for fast dispatch. Software access is through a 16-bit Avalon-MM slave register window with the same read timing as the timer.

## Interface
- `NUM_IRQ`, 8: number of implemented interrupt lines, 1..16; bits at and above `NUM_IRQ` read 0 and ignore writes.
- `MODE_RESET`, 16'h0000: reset value of MODE register (1 = rising-edge, 0 = level).

- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  reset, synchronous, active-low.
- `address`  in  3  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  16  write data.
- `readdata`  out  16  registered read data.
- `irq_in`  in  NUM_IRQ  peripheral interrupt requests, active-high; bit 0 = system timer.
- `irq_out`  out  1  registered CPU interrupt request.

## Operation
- Write strobe: `chipselect && !write_n` at `address`.
- Register map:
  - 0 PENDING: R = pending; W1C clears latched bits of edge-mode lines; ignored for level-mode lines.
  - 1 MASK: R/W enable, reset 0.
  - 2 MODE: R/W per-line mode, reset `MODE_RESET`.
  - 3 ACTIVE: R = pending & mask.
  - 4 VECTOR: R = {valid, 11'b0, index[3:0]}; index = lowest-numbered set bit of ACTIVE; all zero when ACTIVE == 0. Reading does not acknowledge.
  - 5 SWSET: W sets pending bits of edge-mode lines; reads 0.
  - 6, 7: read 0, writes ignored.
- Input stage: `irq_q <= irq_in`; `irq_prev <= irq_q` every cycle.
- Level-mode line: `pending[i] <= irq_q[i]` every cycle; W1C and SWSET have no effect.
- Edge-mode line: set when `irq_q[i] && !irq_prev[i]`, or by SWSET bit; cleared by W1C bit. Set (edge or SWSET) and W1C in the same cycle: set wins.
- MODE write: every line whose mode bit changes has its pending bit cleared that cycle; edge detection resumes next cycle (line already high does not generate an edge).
- `irq_out <= |(pending & mask)` every cycle.
- `readdata <= mux(address)` every cycle regardless of `chipselect`.
- Reset (`reset_n` low at a clock edge): `irq_q`, `irq_prev`, pending, MASK, `readdata`, `irq_out` = 0; MODE = `MODE_RESET`. Reset mid-operation discards all latched interrupts; a line held high through reset is not seen as an edge until it falls and rises again (irq_prev tracks it from the first post-reset cycle).

## Timing
- `irq_in` high before clock edge T0: `irq_q` = 1 after T0, pending = 1 after T1, `irq_out` = 1 after T2.
- Level-mode line deasserting: `irq_out` falls 3 edges after `irq_in` falls (if no other active line).
- W1C at edge T: pending cleared after T, `irq_out` low after T+1.
- MASK write at edge T: `irq_out` reflects new mask after T+1.
- Read: `address` presented at edge T → `readdata` valid after T (1-cycle latency); data reflects register state before T.
- Edge detection needs input low ≥1 cycle between pulses; a 1-cycle pulse is captured.

## Test plan
- Reset, then read addr 0–7 → all 0 except MODE = `MODE_RESET`; `irq_out` = 0.
- MODE = 0x0001, MASK = 0x0001, pulse `irq_in[0]` 1 cycle → PENDING = 0x0001, `irq_out` = 1 two edges after sampling; W1C 0x0001 → PENDING = 0, `irq_out` = 0 one edge later.
- Level line 3 masked, `irq_in[3]` held high → W1C 0x0008 leaves PENDING = 0x0008; drop `irq_in[3]` → PENDING = 0 and `irq_out` = 0 after 3 edges.
- Lines 2 and 5 active, MASK = 0x0024 → VECTOR = 0x8002; clear MASK bit 2 → VECTOR = 0x8005; MASK = 0 → VECTOR = 0x0000, ACTIVE = 0.
- Edge line 1: rising edge coincident with W1C 0x0002 → PENDING bit 1 stays 1; SWSET 0x0002 on cleared line → PENDING = 0x0002.
- Assert `reset_n` low while PENDING = 0x00FF and `irq_in[0]` high → all cleared; after reset, no edge on line 0 until it toggles low then high.
